// File: rtl/norm_shift.sv
// Iterative normalizer: shifts an operand one bit per cycle until its MSB (left)
// or LSB (right) is set, reporting the shift distance and an all-zeros flag.
module norm_shift #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rightleft,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [SW-1:0]    shift_amount,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic             dir;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] res_data;
  logic [SW-1:0]    res_cnt;
  logic             res_zero;

  logic work_zero, target;
  assign work_zero = (work == '0);
  assign target    = dir ? work[0] : work[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: if (work_zero || target) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results live in their own registers so they survive the next operand's
  // load and scan until a new DONE replaces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      dir      <= 1'b0;
      cnt      <= '0;
      res_data <= '0;
      res_cnt  <= '0;
      res_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= data_in;
          dir  <= rightleft;
          cnt  <= '0;
        end
        SCAN: begin
          if (work_zero) begin
            res_data <= '0;
            res_cnt  <= '0;
            res_zero <= 1'b1;
          end else if (target) begin
            res_data <= work;
            res_cnt  <= cnt;
            res_zero <= 1'b0;
          end else begin
            work <= dir ? (work >> 1) : (work << 1);
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out     = res_data;
  assign shift_amount = res_cnt;
  assign zero         = res_zero;

endmodule

// File: tb/tb_norm_shift.sv
// Directed bench for norm_shift: latency, results, backpressure, reset abort.
module tb_norm_shift;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic        rightleft = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [4:0]  shift_amount;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  norm_shift #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rightleft(rightleft), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .shift_amount(shift_amount),
    .zero(zero)
  );

  always #5 clk = ~clk;

  // Presents one operand and counts edges from acceptance to out_valid (-1 on timeout).
  // With noisy set, junk operands are driven on in_valid while the block is busy.
  task automatic send(input logic [31:0] d, input logic rl, input bit noisy, output int lat);
    @(negedge clk);
    in_valid = 1'b1; data_in = d; rightleft = rl;
    @(posedge clk); #1;
    lat = -1;
    if (noisy) begin
      data_in = $urandom; rightleft = ~rl;
    end else begin
      in_valid = 1'b0; data_in = '0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_cmp++; if (shift_amount !== 5'd0) begin n_err++; $display("FAIL reset_shift: got %0d want 0", shift_amount); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
  endtask

  task automatic test_left();
    int lat;
    send(32'h12345678, 1'b0, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL left_latency: got %0d want 4", lat); end
    n_cmp++; if (data_out !== 32'h91A2B3C0) begin n_err++; $display("FAIL left_data: got %h want 91a2b3c0", data_out); end
    n_cmp++; if (shift_amount !== 5'd3) begin n_err++; $display("FAIL left_shift: got %0d want 3", shift_amount); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL left_zero: got %b want 0", zero); end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL left_return_idle: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (data_out !== 32'h91A2B3C0 || shift_amount !== 5'd3) begin n_err++; $display("FAIL left_retained: got %h/%0d want 91a2b3c0/3", data_out, shift_amount); end
  endtask

  task automatic test_right();
    int lat;
    send(32'h12345678, 1'b1, 1'b1, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL right_latency: got %0d want 4", lat); end
    n_cmp++; if (data_out !== 32'h02468ACF) begin n_err++; $display("FAIL right_data: got %h want 02468acf", data_out); end
    n_cmp++; if (shift_amount !== 5'd3) begin n_err++; $display("FAIL right_shift: got %0d want 3", shift_amount); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL right_zero: got %b want 0", zero); end
    consume();
  endtask

  task automatic test_boundary();
    int lat;
    send(32'h00000001, 1'b0, 1'b0, lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL bnd_l1_latency: got %0d want 32", lat); end
    n_cmp++; if (data_out !== 32'h80000000 || shift_amount !== 5'd31) begin n_err++; $display("FAIL bnd_l1_result: got %h/%0d want 80000000/31", data_out, shift_amount); end
    consume();
    send(32'h80000000, 1'b1, 1'b0, lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL bnd_r_latency: got %0d want 32", lat); end
    n_cmp++; if (data_out !== 32'h00000001 || shift_amount !== 5'd31) begin n_err++; $display("FAIL bnd_r_result: got %h/%0d want 00000001/31", data_out, shift_amount); end
    consume();
    send(32'h80000000, 1'b0, 1'b0, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL bnd_l0_latency: got %0d want 1", lat); end
    n_cmp++; if (data_out !== 32'h80000000 || shift_amount !== 5'd0) begin n_err++; $display("FAIL bnd_l0_result: got %h/%0d want 80000000/0", data_out, shift_amount); end
    consume();
  endtask

  task automatic test_zero();
    int lat;
    for (int d = 0; d < 2; d++) begin
      send(32'h0, d[0], 1'b0, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zero_latency dir=%0d: got %0d want 1", d, lat); end
      n_cmp++; if (zero !== 1'b1 || data_out !== 32'h0 || shift_amount !== 5'd0) begin n_err++; $display("FAIL zero_result dir=%0d: got z=%b %h/%0d want 1 0/0", d, zero, data_out, shift_amount); end
      consume();
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL zero_retained dir=%0d: got %b want 1", d, zero); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(32'h00000100, 1'b1, 1'b0, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL bp_latency: got %0d want 9", lat); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 32'h1 || shift_amount !== 5'd8 || zero !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d: got v=%b r=%b %h/%0d z=%b want 1 0 00000001/8 0", c, out_valid, in_ready, data_out, shift_amount, zero);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got v=%b r=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_midscan();
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; data_in = 32'h00000001; rightleft = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL abort_state: got v=%b r=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (data_out !== 32'h0 || shift_amount !== 5'd0 || zero !== 1'b0) begin n_err++; $display("FAIL abort_outputs: got %h/%0d z=%b want 0/0 0", data_out, shift_amount, zero); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got out_valid seen=%b want 0", seen); end
    send(32'h00F00000, 1'b0, 1'b0, lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL after_abort_latency: got %0d want 9", lat); end
    n_cmp++; if (data_out !== 32'hF0000000 || shift_amount !== 5'd8) begin n_err++; $display("FAIL after_abort_result: got %h/%0d want f0000000/8", data_out, shift_amount); end
    consume();
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_boundary();
    test_zero();
    test_backpressure();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
